// File: rtl/idct_transpose_buf_if.sv
// ---------------------------------------------------------------------------
// idct_transpose_buf_if
//
// Handshake and data bundle of the IDCT row-to-column transpose buffer.
//   Row side    : in_valid, in_ready, i0..i7 (row elements 0..7)
//   Column side : out_valid, out_ready, o0..o7 (ok = row k of the column),
//                 out_col (column index), out_last (high on column 7)
//
// Modports:
//   slave  - the transpose buffer itself
//   master - the environment: row producer plus column consumer
// ---------------------------------------------------------------------------
interface idct_transpose_buf_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] i0, i1, i2, i3, i4, i5, i6, i7;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [2:0]   out_col;
    logic         out_last;

    modport slave (
        input  in_valid, i0, i1, i2, i3, i4, i5, i6, i7, out_ready,
        output in_ready, out_valid, o0, o1, o2, o3, o4, o5, o6, o7,
               out_col, out_last
    );

    modport master (
        output in_valid, i0, i1, i2, i3, i4, i5, i6, i7, out_ready,
        input  in_ready, out_valid, o0, o1, o2, o3, o4, o5, o6, o7,
               out_col, out_last
    );
endinterface

// File: rtl/idct_transpose_buf.sv
// ---------------------------------------------------------------------------
// idct_transpose_buf
//
// Collects eight 8-word rows from the IDCT row pass into an 8x8 block store,
// then streams the block back out one column per transfer for the column
// pass. Words are opaque W-bit patterns and pass through bit-exact.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low; clears state and the block store
//   en    - global enable; low freezes all state and blocks both handshakes
//   bus   - idct_transpose_buf_if.slave (row input / column output)
// ---------------------------------------------------------------------------
module idct_transpose_buf #(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    idct_transpose_buf_if.slave bus
);

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [2:0]   r_row_cnt;
    logic [2:0]   r_col_cnt;
    logic [W-1:0] r_buf [8][8];   // r_buf[row][col]

    logic [W-1:0] w_row [8];
    logic         w_in_ready;
    logic         w_out_valid;
    logic         w_accept;
    logic         w_xfer;

    assign w_row[0] = bus.i0;
    assign w_row[1] = bus.i1;
    assign w_row[2] = bus.i2;
    assign w_row[3] = bus.i3;
    assign w_row[4] = bus.i4;
    assign w_row[5] = bus.i5;
    assign w_row[6] = bus.i6;
    assign w_row[7] = bus.i7;

    // Handshakes decode from registered state and en only. in_ready is also
    // gated by reset so it stays low for the whole time reset is held.
    always_comb begin
        w_in_ready  = en & reset & (r_state == ST_FILL);
        w_out_valid = en & (r_state == ST_DRAIN);
        w_accept    = w_in_ready & bus.in_valid;
        w_xfer      = w_out_valid & bus.out_ready;
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:  if (w_accept && r_row_cnt == 3'd7) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_xfer && r_col_cnt == 3'd7)   w_state_nxt = ST_FILL;
            default:  w_state_nxt = ST_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FILL;
        else        r_state <= w_state_nxt;
    end

    // Counters wrap 7 -> 0 naturally in 3 bits, matching the block boundary.
    // NOTE: the block store is deliberately reset: outputs must read 0 after
    // reset and a reset mid-block must not leak stale words downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row_cnt <= '0;
            r_col_cnt <= '0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    r_buf[r][c] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                for (int k = 0; k < 8; k++) begin
                    r_buf[r_row_cnt][k] <= w_row[k];
                end
                r_row_cnt <= r_row_cnt + 3'd1;
            end
            if (w_xfer) begin
                r_col_cnt <= r_col_cnt + 3'd1;
            end
        end
    end

    // Column output: element k of the presented column is row k of the store.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_col   = r_col_cnt;
    assign bus.out_last  = (r_col_cnt == 3'd7);
    assign bus.o0        = r_buf[0][r_col_cnt];
    assign bus.o1        = r_buf[1][r_col_cnt];
    assign bus.o2        = r_buf[2][r_col_cnt];
    assign bus.o3        = r_buf[3][r_col_cnt];
    assign bus.o4        = r_buf[4][r_col_cnt];
    assign bus.o5        = r_buf[5][r_col_cnt];
    assign bus.o6        = r_buf[6][r_col_cnt];
    assign bus.o7        = r_buf[7][r_col_cnt];

endmodule
